// File: rtl/mod_mul_vec_if.sv
// rtl/mod_mul_vec_if.sv - handshake and lane buses of the vector modular multiplier
interface mod_mul_vec_if #(
    parameter int LANES = 4,
    parameter int W     = 12
);
    logic               valid_i;
    logic               ready_o;
    logic               mode_i;
    logic [LANES*W-1:0] op1_i;
    logic [LANES*W-1:0] op2_i;
    logic [LANES*W-1:0] acc_i;
    logic               valid_o;
    logic               ready_i;
    logic [LANES*W-1:0] result_o;
    logic               busy_o;

    modport master (
        output valid_i, mode_i, op1_i, op2_i, acc_i, ready_i,
        input  ready_o, valid_o, result_o, busy_o
    );

    modport slave (
        input  valid_i, mode_i, op1_i, op2_i, acc_i, ready_i,
        output ready_o, valid_o, result_o, busy_o
    );
endinterface

// File: rtl/mod_mul_vec.sv
// rtl/mod_mul_vec.sv - LANES-wide (op1*op2 [+acc]) mod Q pipeline with Barrett reduction
module mod_mul_vec #(
    parameter int LANES = 4,
    parameter int Q     = 3329,
    parameter int W     = 12,
    parameter int LAT   = 3
) (
    input  logic          clk,
    input  logic          rst,
    mod_mul_vec_if.slave  bus
);
    localparam int M = 2 * W + 1;
    localparam int R = W + 2;
    localparam logic [M:0]   TWO_M = {1'b1, {M{1'b0}}};
    localparam logic [M-1:0] MU    = M'(TWO_M / (M + 1)'(Q));
    localparam logic [M-1:0] QM    = M'(Q);
    localparam logic [R-1:0] QR    = R'(Q);

    logic           en;
    logic [LAT-1:0] vld;
    logic           mode_q;
    logic [W-1:0]   op1_q [LANES];
    logic [W-1:0]   op2_q [LANES];
    logic [W-1:0]   acc_q [LANES];
    logic [R-1:0]   mid_q [LAT-2][LANES];
    logic [W-1:0]   res_q [LANES];
    logic [R-1:0]   red   [LANES];
    logic [W-1:0]   fin   [LANES];

    // Estimated quotient is floor(x/Q) or one less, so the remainder is below 2Q.
    function automatic logic [R-1:0] barrett(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c, input logic m);
        logic [M-1:0]   x;
        logic [2*M-1:0] xm;
        logic [M-1:0]   qe;
        logic [M-1:0]   r;
        x  = M'(a) * M'(b) + (m ? M'(c) : '0);
        xm = (2 * M)'(x) * (2 * M)'(MU);
        qe = M'(xm >> M);
        r  = x - qe * QM;
        return R'(r);
    endfunction

    function automatic logic [W-1:0] fold(input logic [R-1:0] r);
        logic [R-1:0] t;
        t = r;
        if (t >= QR) t = t - QR;
        if (t >= QR) t = t - QR;
        return W'(t);
    endfunction

    assign en          = !bus.valid_o || bus.ready_i;
    assign bus.ready_o = en;
    assign bus.valid_o = vld[LAT-1];
    assign bus.busy_o  = |vld;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            red[k] = barrett(op1_q[k], op2_q[k], acc_q[k], mode_q);
            fin[k] = fold(mid_q[LAT-3][k]);
        end
    end

    always_comb begin
        bus.result_o = '0;
        for (int k = 0; k < LANES; k++) begin
            bus.result_o[k*W +: W] = res_q[k];
        end
    end

    // Every stage moves together on en, so bubbles keep their slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else if (en) begin
            vld <= {vld[LAT-2:0], bus.valid_i && en};
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mode_q <= bus.mode_i;
            for (int k = 0; k < LANES; k++) begin
                op1_q[k] <= bus.op1_i[k*W +: W];
                op2_q[k] <= bus.op2_i[k*W +: W];
                acc_q[k] <= bus.acc_i[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < LANES; k++) begin
                mid_q[0][k] <= red[k];
                for (int s = 1; s < LAT - 2; s++) begin
                    mid_q[s][k] <= mid_q[s-1][k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LANES; k++) begin
                res_q[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < LANES; k++) begin
                res_q[k] <= fin[k];
            end
        end
    end
endmodule

// File: tb/tb_mod_mul_vec.sv
// tb/tb_mod_mul_vec.sv - randomized scoreboard bench for mod_mul_vec (4-lane LAT=3 and 1-lane LAT=5)
module tb_mod_mul_vec;
    localparam int Q    = 3329;
    localparam int LAT1 = 3;
    localparam int LAT2 = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_mul_vec_if #(.LANES(4), .W(12)) bus1 ();
    mod_mul_vec_if #(.LANES(1), .W(12)) bus2 ();

    mod_mul_vec #(.LANES(4), .Q(Q), .W(12), .LAT(LAT1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mod_mul_vec #(.LANES(1), .Q(Q), .W(12), .LAT(LAT2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int          total = 0;
    int          bad   = 0;
    logic [47:0] exp_q [2][$];
    int          age_q [2][$];
    int          lat_of [2];
    bit          stall [2];
    logic [47:0] last_res [2];
    int          acc_cnt [2];
    int          out_cnt [2];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int unsigned mm(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input bit m);
        return (a * b + (m ? c : 0)) % Q;
    endfunction

    function automatic logic [47:0] model(input logic [47:0] a, input logic [47:0] b,
                                          input logic [47:0] c, input bit m, input int lanes);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < lanes; k++)
            r[k*12 +: 12] = 12'(mm(a[k*12 +: 12], b[k*12 +: 12], c[k*12 +: 12], m));
        return r;
    endfunction

    function automatic logic [47:0] rnd_ops();
        logic [47:0] r;
        for (int k = 0; k < 4; k++)
            r[k*12 +: 12] = ($urandom_range(0, 7) == 0) ? 12'hfff : 12'($urandom_range(0, 4095));
        return r;
    endfunction

    // Each accepted beat ages by one per advancing edge and must surface at age LAT-1.
    task automatic step(input int id, input bit vin, input bit rdo, input bit vo, input bit rdi,
                        input bit busy, input logic [47:0] res, input logic [47:0] expn);
        string nm;
        bit    exp_v;
        nm = (id == 0) ? "d4" : "d1";
        chk($sformatf("%s.ready", nm), 48'(rdo), 48'(!vo || rdi));
        chk($sformatf("%s.busy", nm), 48'(busy), 48'(exp_q[id].size() != 0));
        exp_v = (exp_q[id].size() != 0) && (age_q[id][0] == lat_of[id] - 1);
        chk($sformatf("%s.valid", nm), 48'(vo), 48'(exp_v));
        if (stall[id]) begin
            chk($sformatf("%s.hold_valid", nm), 48'(vo), 48'(1));
            chk($sformatf("%s.hold_result", nm), res, last_res[id]);
        end
        if (vo && rdi && exp_q[id].size() != 0) begin
            chk($sformatf("%s.result", nm), res, exp_q[id][0]);
            void'(exp_q[id].pop_front());
            void'(age_q[id].pop_front());
            out_cnt[id]++;
        end
        stall[id]    = vo && !rdi;
        last_res[id] = res;
        if (rdo) begin
            for (int i = 0; i < age_q[id].size(); i++) age_q[id][i] = age_q[id][i] + 1;
            if (vin) begin
                exp_q[id].push_back(expn);
                age_q[id].push_back(0);
                acc_cnt[id]++;
            end
        end
    endtask

    task automatic cyc(input bit v, input bit m, input logic [47:0] a, input logic [47:0] b,
                       input logic [47:0] c, input bit rdy, input bit use_lit, input logic [47:0] lit);
        bus1.valid_i = v;  bus1.mode_i = m;  bus1.ready_i = rdy;
        bus1.op1_i = a;    bus1.op2_i = b;   bus1.acc_i = c;
        bus2.valid_i = v;  bus2.mode_i = m;  bus2.ready_i = rdy;
        bus2.op1_i = a[11:0]; bus2.op2_i = b[11:0]; bus2.acc_i = c[11:0];
        #1;
        step(0, v, bus1.ready_o, bus1.valid_o, rdy, bus1.busy_o, bus1.result_o,
             use_lit ? lit : model(a, b, c, m, 4));
        step(1, v, bus2.ready_o, bus2.valid_o, rdy, bus2.busy_o, 48'(bus2.result_o),
             model(a, b, c, m, 1));
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 60) begin
            cyc(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
            n++;
        end
        chk($sformatf("%s.drain_d4", name), 48'(exp_q[0].size()), 48'(0));
        chk($sformatf("%s.drain_d1", name), 48'(exp_q[1].size()), 48'(0));
    endtask

    task automatic check_reset(input string name);
        chk($sformatf("%s.d4_valid", name), 48'(bus1.valid_o), 48'(0));
        chk($sformatf("%s.d4_busy", name), 48'(bus1.busy_o), 48'(0));
        chk($sformatf("%s.d4_result", name), bus1.result_o, 48'(0));
        chk($sformatf("%s.d4_ready", name), 48'(bus1.ready_o), 48'(1));
        chk($sformatf("%s.d1_valid", name), 48'(bus2.valid_o), 48'(0));
        chk($sformatf("%s.d1_busy", name), 48'(bus2.busy_o), 48'(0));
        chk($sformatf("%s.d1_result", name), 48'(bus2.result_o), 48'(0));
        chk($sformatf("%s.d1_ready", name), 48'(bus2.ready_o), 48'(1));
        for (int id = 0; id < 2; id++) begin
            exp_q[id].delete();
            age_q[id].delete();
            stall[id] = 1'b0;
        end
    endtask

    initial begin
        int base;
        int cy;
        int outs;
        lat_of[0] = LAT1;
        lat_of[1] = LAT2;
        for (int id = 0; id < 2; id++) begin
            stall[id] = 1'b0; last_res[id] = '0; acc_cnt[id] = 0; out_cnt[id] = 0;
        end
        rst = 1'b0;
        bus1.valid_i = 0; bus1.mode_i = 0; bus1.ready_i = 1; bus1.op1_i = '0; bus1.op2_i = '0; bus1.acc_i = '0;
        bus2.valid_i = 0; bus2.mode_i = 0; bus2.ready_i = 1; bus2.op1_i = '0; bus2.op2_i = '0; bus2.acc_i = '0;
        #1;
        check_reset("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        chk("model.corner_mul", 48'(mm(4095, 4095, 0, 1'b0)), 48'd852);
        chk("model.mac_zero", 48'(mm(3328, 3328, 3328, 1'b1)), 48'd0);
        chk("model.mac_wrap", 48'(mm(2, 1665, 4095, 1'b1)), 48'd767);

        // Lanes packed {lane3, lane2, lane1, lane0}.
        cyc(1'b1, 1'b0, {12'd4095, 12'd3328, 12'd1, 12'd0}, {12'd4095, 12'd3328, 12'd3328, 12'd0},
            rnd_ops(), 1'b1, 1'b1, {12'd852, 12'd1, 12'd3328, 12'd0});
        cyc(1'b1, 1'b1, {12'd4095, 12'd0, 12'd2, 12'd3328}, {12'd4095, 12'd0, 12'd1665, 12'd3328},
            {12'd4095, 12'd0, 12'd4095, 12'd3328}, 1'b1, 1'b1, {12'd1618, 12'd0, 12'd767, 12'd0});
        drain("corner");

        base = acc_cnt[0];
        outs = out_cnt[0];
        cy = 0;
        while (acc_cnt[0] - base < 20 && cy < 200) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), rnd_ops(), rnd_ops(), rnd_ops(),
                !(cy >= 5 && cy <= 9), 1'b0, '0);
            cy++;
        end
        drain("bp");
        chk("bp.count", 48'(out_cnt[0] - outs), 48'd20);

        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'($urandom_range(0, 1)), rnd_ops(), rnd_ops(), rnd_ops(), 1'b1, 1'b0, '0);
        chk("rst.inflight", 48'(exp_q[0].size() >= LAT1), 48'(1));
        rst = 1'b0;
        bus1.valid_i = 0;
        bus2.valid_i = 0;
        #1;
        check_reset("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, rnd_ops(), rnd_ops(), rnd_ops(), 1'b1, 1'b0, '0);
        drain("postrst");

        base = acc_cnt[0];
        outs = out_cnt[0];
        cy = 0;
        while (acc_cnt[0] - base < 10000 && cy < 60000) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_ops(), rnd_ops(), rnd_ops(),
                1'($urandom_range(0, 1)), 1'b0, '0);
            cy++;
        end
        chk("stress.accepted", 48'(acc_cnt[0] - base), 48'd10000);
        drain("stress");
        chk("stress.count", 48'(out_cnt[0] - outs), 48'd10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
